ahb_lite_req_arbiter: RTL and testbench
=======================================

AHB_LITE_REQ_ARBITER -- requirements
Module: ahb_lite_req_arbiter

Interface
REQ-001 The block SHALL expose the following parameter:
  HPROT_VAL  4'b0011  constant value driven on HPROT (data access, privileged).
REQ-002 The block SHALL have the following ports:
  HCLK  in  1  clock; all state updates on rising edge
  HRESETn  in  1  reset, asynchronous, active-low
  req  in  2  per-requester transfer request, bit x = requester x, level
  wr  in  2  per-requester direction, 1 = write, 0 = read
  addr  in  64  {addr1, addr0}, 32 bits each
  wdata  in  64  {wdata1, wdata0}, 32 bits each
  size  in  6  {size1, size0}, 3 bits each, HSIZE encoding
  ack  out  2  one-cycle completion pulse per requester
  err  out  2  one-cycle error flag, coincident with ack
  rdata  out  32  read data of the last completed read
  busy  out  1  high whenever state is not IDLE
  HREADY  in  1  slave transfer-done
  HRESP  in  1  0 = OKAY, 1 = ERROR
  HRDATA  in  32  slave read data
  HADDR  out  32  transfer address
  HWRITE  out  1  transfer direction
  HSIZE  out  3  transfer size
  HBURST  out  3  burst type
  HPROT  out  4  protection
  HTRANS  out  2  00 = IDLE, 10 = NONSEQ
  HMASTLOCK  out  1  locked transfer
  HWDATA  out  32  write data

Function
REQ-003 All outputs SHALL be registered; HBURST SHALL be constant 3'b000 (SINGLE), HMASTLOCK constant 0, HPROT constant HPROT_VAL.
REQ-004 The FSM SHALL have the states IDLE, ADDR, DATA and ERR, and SHALL run one non-pipelined single transfer at a time.
REQ-005 IDLE: when any req bit is high and ack is 0, the FSM SHALL grant one requester, latch its wr/addr/wdata/size, drive HTRANS=NONSEQ with HADDR/HWRITE/HSIZE from the latched values on the next cycle, and enter ADDR.
REQ-006 When ack is 1 in IDLE, req SHALL be ignored for that cycle (one turnaround cycle), so a requester dropping req on the ack cycle never causes a duplicate transfer.
REQ-007 Arbitration SHALL be round-robin. With one requester active, that requester is granted. With both active, the requester not granted last time is granted. After reset, the pointer favours requester 0.
REQ-008 ADDR: HTRANS SHALL remain NONSEQ until HREADY=1 is sampled. On that edge, HTRANS SHALL become IDLE, HWDATA SHALL be driven with the latched wdata (write) or held (read), and the FSM SHALL enter DATA.
REQ-009 DATA with HREADY=1 and HRESP=0: the FSM SHALL pulse ack[g]=1 (err[g]=0) for one cycle, load rdata from HRDATA if the transfer was a read, and return to IDLE. With HREADY=0 and HRESP=0, it SHALL wait in DATA with all outputs held.
REQ-010 DATA with HREADY=0 and HRESP=1: the FSM SHALL enter ERR. In ERR with HREADY=1 and HRESP=1, it SHALL pulse ack[g]=1 and err[g]=1 for one cycle, leave rdata unchanged, and return to IDLE.
REQ-011 HRESP=1 with HREADY=1 seen in DATA (a one-cycle error, protocol violation) SHALL be handled as an error completion, identical to REQ-010.
REQ-012 Latency with zero wait states: req sampled at edge N -> NONSEQ visible after N -> data phase after N+1 -> ack high after N+2. Each HREADY-low cycle adds one cycle.
REQ-013 size and addr SHALL be forwarded unchanged: no alignment or size checking. Write data SHALL be the full 32-bit lane, with no byte-lane steering.
REQ-014 At most one ack bit SHALL be high in any cycle; ack and err SHALL never be high for the non-granted requester.

Reset
REQ-015 On HRESETn low, the block SHALL immediately (asynchronously) force: FSM to IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, ack=0, err=0, rdata=0, busy=0, round-robin pointer favouring requester 0.
REQ-016 Reset asserted mid-transfer SHALL abort without any ack or err pulse. The first request after release SHALL be arbitrated afresh.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
  - req=01, wr0=1, addr0=0x100, wdata0=0xDEADBEEF, HREADY=1 -> NONSEQ one cycle at 0x100, HWDATA=0xDEADBEEF next cycle, ack=01, err=00 after two more edges.
  - req=10, read, addr1=0x200, HRDATA=0x12345678, two HREADY-low cycles in the data phase -> ack=10 two cycles later than the zero-wait case, rdata=0x12345678.
  - req=11 held for four transfers -> grants in order 0,1,0,1, each followed by one IDLE turnaround cycle.
  - Write to 0x300 with HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> ack=01, err=01, rdata unchanged.
  - HRESETn pulsed low during DATA of a write -> HTRANS=00 and all outputs at reset values immediately, no ack, next req=10 served first.

Source files
------------

// File: rtl/ahb_lite_req_arbiter_if.sv
// Bundle of the requester-side handshake and the AHB-Lite master bus for the
// two-requester arbiter.
interface ahb_lite_req_arbiter_if;
   logic [1:0]  req;
   logic [1:0]  wr;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [5:0]  size;
   logic [1:0]  ack;
   logic [1:0]  err;
   logic [31:0] rdata;
   logic        busy;
   logic        HREADY;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;

   modport master (
      input  req, wr, addr, wdata, size, HREADY, HRESP, HRDATA,
      output ack, err, rdata, busy, HADDR, HWRITE, HSIZE, HBURST, HPROT,
             HTRANS, HMASTLOCK, HWDATA
   );

   modport slave (
      output req, wr, addr, wdata, size, HREADY, HRESP, HRDATA,
      input  ack, err, rdata, busy, HADDR, HWRITE, HSIZE, HBURST, HPROT,
             HTRANS, HMASTLOCK, HWDATA
   );
endinterface

// File: rtl/ahb_lite_req_arbiter.sv
// Round-robin arbiter for two requesters driving one AHB-Lite master port,
// one non-pipelined SINGLE transfer at a time.
module ahb_lite_req_arbiter #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   ahb_lite_req_arbiter_if.master  bus
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   state_t      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        prio_q, prio_d;
   logic [1:0]  htrans_q, htrans_d;
   logic [31:0] haddr_q, haddr_d;
   logic        hwrite_q, hwrite_d;
   logic [2:0]  hsize_q, hsize_d;
   logic [31:0] wdata_lat_q, wdata_lat_d;
   logic [31:0] hwdata_q, hwdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  ack_q, ack_d;
   logic [1:0]  err_q, err_d;
   logic        busy_q, busy_d;
   logic        g;
   logic [1:0]  gnt_onehot;

   assign gnt_onehot = gnt_q ? 2'b10 : 2'b01;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      prio_d      = prio_q;
      htrans_d    = htrans_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      wdata_lat_d = wdata_lat_q;
      hwdata_d    = hwdata_q;
      rdata_d     = rdata_q;
      ack_d       = 2'b00;
      err_d       = 2'b00;
      g           = 1'b0;
      case (state_q)
         IDLE: begin
            // ack_q high means last cycle completed: skip one cycle so a
            // requester still holding req on its ack cycle is not re-served.
            if (|bus.req && ack_q == 2'b00) begin
               g           = (bus.req == 2'b11) ? prio_q : bus.req[1];
               gnt_d       = g;
               prio_d      = ~g;
               haddr_d     = g ? bus.addr[63:32]  : bus.addr[31:0];
               wdata_lat_d = g ? bus.wdata[63:32] : bus.wdata[31:0];
               hsize_d     = g ? bus.size[5:3]    : bus.size[2:0];
               hwrite_d    = bus.wr[g];
               htrans_d    = TR_NONSEQ;
               state_d     = ADDR;
            end
         end
         ADDR: begin
            if (bus.HREADY) begin
               htrans_d = TR_IDLE;
               if (hwrite_q) hwdata_d = wdata_lat_q;
               state_d  = DATA;
            end
         end
         DATA: begin
            if (bus.HREADY) begin
               // A single-cycle ERROR response is still treated as an error completion.
               ack_d   = gnt_onehot;
               err_d   = bus.HRESP ? gnt_onehot : 2'b00;
               if (!bus.HRESP && !hwrite_q) rdata_d = bus.HRDATA;
               state_d = IDLE;
            end else if (bus.HRESP) begin
               state_d = ERR;
            end
         end
         ERR: begin
            if (bus.HREADY) begin
               ack_d   = gnt_onehot;
               err_d   = gnt_onehot;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_d = (state_d != IDLE);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= IDLE;
         gnt_q       <= 1'b0;
         prio_q      <= 1'b0;
         htrans_q    <= TR_IDLE;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         hsize_q     <= '0;
         wdata_lat_q <= '0;
         hwdata_q    <= '0;
         rdata_q     <= '0;
         ack_q       <= '0;
         err_q       <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         prio_q      <= prio_d;
         htrans_q    <= htrans_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         wdata_lat_q <= wdata_lat_d;
         hwdata_q    <= hwdata_d;
         rdata_q     <= rdata_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.HTRANS    = htrans_q;
   assign bus.HADDR     = haddr_q;
   assign bus.HWRITE    = hwrite_q;
   assign bus.HSIZE     = hsize_q;
   assign bus.HWDATA    = hwdata_q;
   assign bus.HBURST    = 3'b000;
   assign bus.HPROT     = HPROT_VAL;
   assign bus.HMASTLOCK = 1'b0;
   assign bus.ack       = ack_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ahb_lite_req_arbiter.sv
// Directed bench for ahb_lite_req_arbiter: hand-computed expectations per scenario.
module tb_ahb_lite_req_arbiter;
   logic HCLK = 1'b0;
   logic HRESETn;
   int   n_chk  = 0;
   int   n_pass = 0;

   ahb_lite_req_arbiter_if bif ();

   ahb_lite_req_arbiter #(.HPROT_VAL(4'b0011)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bif)
   );

   always #5 HCLK = ~HCLK;

   // advance to just after the next rising edge
   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic test_reset();
      HRESETn = 1'b1;
      bif.req = 2'b00; bif.wr = 2'b00; bif.addr = '0; bif.wdata = '0; bif.size = '0;
      bif.HREADY = 1'b1; bif.HRESP = 1'b0; bif.HRDATA = '0;
      #1;
      HRESETn = 1'b0;
      #1;
      n_chk++; if (bif.HTRANS !== 2'b00) $display("FAIL rst_htrans got=%h exp=00", bif.HTRANS); else n_pass++;
      n_chk++; if (bif.HADDR !== 32'h0) $display("FAIL rst_haddr got=%h exp=0", bif.HADDR); else n_pass++;
      n_chk++; if ({bif.ack, bif.err, bif.busy} !== 5'b0) $display("FAIL rst_ack_err_busy got=%b exp=00000", {bif.ack, bif.err, bif.busy}); else n_pass++;
      n_chk++; if (bif.rdata !== 32'h0 || bif.HWDATA !== 32'h0) $display("FAIL rst_data got=%h/%h exp=0/0", bif.rdata, bif.HWDATA); else n_pass++;
      n_chk++; if ({bif.HBURST, bif.HPROT, bif.HMASTLOCK} !== 8'b000_0011_0) $display("FAIL rst_consts got=%b exp=00000110", {bif.HBURST, bif.HPROT, bif.HMASTLOCK}); else n_pass++;
      bif.req = 2'b11;
      step();
      step();
      n_chk++; if (bif.HTRANS !== 2'b00 || bif.busy !== 1'b0) $display("FAIL rst_held got=%h/%b exp=00/0", bif.HTRANS, bif.busy); else n_pass++;
      bif.req = 2'b00;
      @(negedge HCLK);
      HRESETn = 1'b1;
      step();
   endtask

   task automatic test_write();
      bif.req = 2'b01; bif.wr = 2'b01; bif.addr[31:0] = 32'h100; bif.wdata[31:0] = 32'hDEADBEEF;
      bif.size[2:0] = 3'd2; bif.HREADY = 1'b1;
      step();
      n_chk++; if (bif.HTRANS !== 2'b10 || bif.HADDR !== 32'h100) $display("FAIL wr_addr_phase got=%h/%h exp=10/00000100", bif.HTRANS, bif.HADDR); else n_pass++;
      n_chk++; if (bif.HWRITE !== 1'b1 || bif.HSIZE !== 3'd2 || bif.busy !== 1'b1) $display("FAIL wr_ctrl got=%b/%0d/%b exp=1/2/1", bif.HWRITE, bif.HSIZE, bif.busy); else n_pass++;
      step();
      n_chk++; if (bif.HTRANS !== 2'b00 || bif.HWDATA !== 32'hDEADBEEF) $display("FAIL wr_data_phase got=%h/%h exp=00/deadbeef", bif.HTRANS, bif.HWDATA); else n_pass++;
      n_chk++; if (bif.ack !== 2'b00) $display("FAIL wr_early_ack got=%b exp=00", bif.ack); else n_pass++;
      step();
      n_chk++; if (bif.ack !== 2'b01 || bif.err !== 2'b00) $display("FAIL wr_ack got=%b/%b exp=01/00", bif.ack, bif.err); else n_pass++;
      n_chk++; if (bif.busy !== 1'b0) $display("FAIL wr_busy_done got=%b exp=0", bif.busy); else n_pass++;
      bif.req = 2'b00;
      step();
      n_chk++; if (bif.ack !== 2'b00 || bif.HTRANS !== 2'b00) $display("FAIL wr_after got=%b/%h exp=00/00", bif.ack, bif.HTRANS); else n_pass++;
   endtask

   task automatic test_read_wait();
      bif.req = 2'b10; bif.wr = 2'b00; bif.addr[63:32] = 32'h200; bif.size[5:3] = 3'd2;
      bif.HRDATA = 32'h12345678; bif.HREADY = 1'b1;
      step();
      n_chk++; if (bif.HTRANS !== 2'b10 || bif.HADDR !== 32'h200 || bif.HWRITE !== 1'b0) $display("FAIL rd_addr_phase got=%h/%h/%b exp=10/00000200/0", bif.HTRANS, bif.HADDR, bif.HWRITE); else n_pass++;
      step();
      n_chk++; if (bif.HWDATA !== 32'hDEADBEEF) $display("FAIL rd_hwdata_held got=%h exp=deadbeef", bif.HWDATA); else n_pass++;
      bif.HREADY = 1'b0;
      step();
      n_chk++; if (bif.ack !== 2'b00 || bif.busy !== 1'b1) $display("FAIL rd_wait1 got=%b/%b exp=00/1", bif.ack, bif.busy); else n_pass++;
      step();
      n_chk++; if (bif.ack !== 2'b00) $display("FAIL rd_wait2 got=%b exp=00", bif.ack); else n_pass++;
      bif.HREADY = 1'b1;
      step();
      n_chk++; if (bif.ack !== 2'b10 || bif.err !== 2'b00) $display("FAIL rd_ack got=%b/%b exp=10/00", bif.ack, bif.err); else n_pass++;
      n_chk++; if (bif.rdata !== 32'h12345678) $display("FAIL rd_rdata got=%h exp=12345678", bif.rdata); else n_pass++;
      bif.req = 2'b00;
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_addr;
      bif.req = 2'b11; bif.wr = 2'b00; bif.addr = {32'h500, 32'h400}; bif.HREADY = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_addr = (k % 2 == 1) ? 32'h500 : 32'h400;
         bif.HRDATA = 32'hA0000000 + k;
         step();
         n_chk++; if (bif.HTRANS !== 2'b10 || bif.HADDR !== exp_addr) $display("FAIL b2b_grant%0d got=%h/%h exp=10/%h", k, bif.HTRANS, bif.HADDR, exp_addr); else n_pass++;
         step();
         step();
         n_chk++; if (bif.ack !== ((k % 2 == 1) ? 2'b10 : 2'b01) || bif.rdata !== 32'hA0000000 + k) $display("FAIL b2b_ack%0d got=%b/%h exp=%0d/%h", k, bif.ack, bif.rdata, k % 2, 32'hA0000000 + k); else n_pass++;
         step();
         n_chk++; if (bif.HTRANS !== 2'b00 || bif.ack !== 2'b00) $display("FAIL b2b_turn%0d got=%h/%b exp=00/00", k, bif.HTRANS, bif.ack); else n_pass++;
      end
      bif.req = 2'b00;
      step();
   endtask

   task automatic test_err();
      bif.req = 2'b01; bif.wr = 2'b01; bif.addr[31:0] = 32'h300; bif.wdata[31:0] = 32'hCAFEF00D;
      bif.HREADY = 1'b1; bif.HRESP = 1'b0;
      step();
      n_chk++; if (bif.HADDR !== 32'h300 || bif.HTRANS !== 2'b10) $display("FAIL err_addr got=%h/%h exp=00000300/10", bif.HADDR, bif.HTRANS); else n_pass++;
      step();
      bif.HREADY = 1'b0; bif.HRESP = 1'b1;
      step();
      n_chk++; if (bif.ack !== 2'b00 || bif.busy !== 1'b1) $display("FAIL err_first got=%b/%b exp=00/1", bif.ack, bif.busy); else n_pass++;
      bif.HREADY = 1'b1;
      step();
      n_chk++; if (bif.ack !== 2'b01 || bif.err !== 2'b01) $display("FAIL err_ack got=%b/%b exp=01/01", bif.ack, bif.err); else n_pass++;
      n_chk++; if (bif.rdata !== 32'hA0000003) $display("FAIL err_rdata got=%h exp=a0000003", bif.rdata); else n_pass++;
      bif.HRESP = 1'b0; bif.req = 2'b00;
      step();
      n_chk++; if (bif.ack !== 2'b00 || bif.err !== 2'b00) $display("FAIL err_clear got=%b/%b exp=00/00", bif.ack, bif.err); else n_pass++;
   endtask

   task automatic test_err_onecycle();
      bif.req = 2'b10; bif.wr = 2'b00; bif.addr[63:32] = 32'h700; bif.HRDATA = 32'hBAD0BAD0;
      bif.HREADY = 1'b1; bif.HRESP = 1'b0;
      step();
      step();
      bif.HRESP = 1'b1;
      step();
      n_chk++; if (bif.ack !== 2'b10 || bif.err !== 2'b10 || bif.rdata !== 32'hA0000003) $display("FAIL err1c got=%b/%b/%h exp=10/10/a0000003", bif.ack, bif.err, bif.rdata); else n_pass++;
      bif.HRESP = 1'b0; bif.req = 2'b00;
      step();
   endtask

   task automatic test_reset_mid();
      bif.req = 2'b01; bif.wr = 2'b01; bif.addr[31:0] = 32'h800; bif.wdata[31:0] = 32'h0BADF00D;
      bif.HREADY = 1'b1;
      step();
      step();
      n_chk++; if (bif.HWDATA !== 32'h0BADF00D || bif.busy !== 1'b1) $display("FAIL rm_data_phase got=%h/%b exp=0badf00d/1", bif.HWDATA, bif.busy); else n_pass++;
      bif.HREADY = 1'b0;
      #2;
      HRESETn = 1'b0;
      #1;
      n_chk++; if (bif.HTRANS !== 2'b00 || bif.HADDR !== 32'h0 || bif.HWRITE !== 1'b0 || bif.HSIZE !== 3'd0) $display("FAIL rm_bus got=%h/%h/%b/%0d exp=00/0/0/0", bif.HTRANS, bif.HADDR, bif.HWRITE, bif.HSIZE); else n_pass++;
      n_chk++; if (bif.HWDATA !== 32'h0 || bif.rdata !== 32'h0 || {bif.ack, bif.err, bif.busy} !== 5'b0) $display("FAIL rm_outs got=%h/%h/%b exp=0/0/00000", bif.HWDATA, bif.rdata, {bif.ack, bif.err, bif.busy}); else n_pass++;
      bif.HREADY = 1'b1;
      step();
      n_chk++; if (bif.ack !== 2'b00 || bif.err !== 2'b00) $display("FAIL rm_no_ack got=%b/%b exp=00/00", bif.ack, bif.err); else n_pass++;
      bif.req = 2'b10; bif.wr = 2'b00; bif.addr[63:32] = 32'h600; bif.HRDATA = 32'h55AA55AA;
      @(negedge HCLK);
      HRESETn = 1'b1;
      step();
      n_chk++; if (bif.HTRANS !== 2'b10 || bif.HADDR !== 32'h600) $display("FAIL rm_fresh got=%h/%h exp=10/00000600", bif.HTRANS, bif.HADDR); else n_pass++;
      step();
      step();
      n_chk++; if (bif.ack !== 2'b10 || bif.rdata !== 32'h55AA55AA) $display("FAIL rm_ack got=%b/%h exp=10/55aa55aa", bif.ack, bif.rdata); else n_pass++;
      bif.req = 2'b00;
      step();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_back_to_back();
      test_err();
      test_err_onecycle();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
